// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle instruction sequencer for the NPC core.
// Owns the PC and fetches one instruction at a time over a valid/ready port.
// It then holds the instruction for decode/execute and waits for exu_done.
// Finally it forms the next PC from the (pca_src, pcb_src) adder selects.
// It halts on ebreak and traps on a misaligned target.
//
// Ports:
//   clk, rst                        rising-edge clock, async active-high reset
//   ifu_req_valid/ready/addr        fetch request (addr is always pc)
//   ifu_rsp_valid/ready/inst        fetch response
//   inst_valid, inst, pc            current instruction to decode/execute
//   exu_done, halt_req              execute completion and ebreak request
//   pca_src, pcb_src, imm, rs1,
//   is_jalr                         branch target operands
//   retire                          one pulse per completed instruction (comb)
//   halted, misalign, misalign_addr sticky terminal status
module pc_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_rsp_valid,
    output logic            ifu_rsp_ready,
    input  logic [31:0]     ifu_rsp_inst,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    input  logic            exu_done,
    input  logic            pca_src,
    input  logic            pcb_src,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            is_jalr,
    input  logic            halt_req,
    output logic            retire,
    output logic            halted,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT,
        S_TRAP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     inst_next;
    logic [XLEN-1:0] misalign_addr_next;
    logic            halted_next;
    logic            misalign_next;

    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    logic [XLEN-1:0] target;
    logic            target_bad;

    assign ifu_req_addr = pc;

    // Branch target: (4 | imm) + (pc | rs1), jalr clears bit 0, then alignment test
    always_comb begin
        add_a      = pca_src ? imm : XLEN'(4);
        add_b      = pcb_src ? rs1 : pc;
        target     = add_a + add_b;
        if (is_jalr) begin
            target[0] = 1'b0;
        end
        target_bad = (target[1:0] != 2'b00);
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_next         = state;
        pc_next            = pc;
        inst_next          = inst;
        misalign_addr_next = misalign_addr;
        halted_next        = halted;
        misalign_next      = misalign;
        ifu_req_valid      = 1'b0;
        ifu_rsp_ready      = 1'b0;
        inst_valid         = 1'b0;
        retire             = 1'b0;

        case (state)
            S_FETCH: begin
                // State already sits in FETCH while rst is held; keep the request quiet then
                ifu_req_valid = !rst;
                if (ifu_req_valid && ifu_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                ifu_rsp_ready = 1'b1;
                if (ifu_rsp_valid) begin
                    inst_next  = ifu_rsp_inst;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                if (exu_done) begin
                    if (halt_req) begin
                        retire      = 1'b1;
                        halted_next = 1'b1;
                        state_next  = S_HALT;
                    end else if (target_bad) begin
                        // Trapping instruction does not retire
                        misalign_next      = 1'b1;
                        misalign_addr_next = target;
                        state_next         = S_TRAP;
                    end else begin
                        retire     = 1'b1;
                        pc_next    = target;
                        state_next = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_FETCH;
            pc            <= RESET_PC;
            inst          <= '0;
            misalign_addr <= '0;
            halted        <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            inst          <= inst_next;
            misalign_addr <= misalign_addr_next;
            halted        <= halted_next;
            misalign      <= misalign_next;
        end
    end

endmodule
